chaos_display_ctrl: RTL and testbench
=====================================

# chaos_display_ctrl

Parametrised display/control front end for the chaos-map VGA pipeline. It registers the per-pixel colour from the map calculator, sequences display and calculation enable after reset, and scans an active-low key bank once per vertical blanking interval. A debounced key press selects a sample preset and issues a fixed-length reset pulse to the calculator.

## Interface
Parameters:
- NKEYS, 10, number of active-low preset keys; key i selects preset i
- SEL_W, $clog2(NKEYS), width of sample_num
- COLOR_W, 1, bits per colour channel
- TICK_DIV, 2**22, CLK cycles per startup tick (≥2)
- STARTUP_DISP, 6, tick count at which disp_en asserts
- STARTUP_CALC, 15, tick count at which calc_en asserts (> STARTUP_DISP)
- DEB_FRAMES, 2, consecutive blanking intervals a key must be seen low (≥1)
- RST_CYC, 4, length of calc_rst_n low pulse in CLK cycles (≥1)

Ports:
- CLK  in  1  system/pixel clock
- RST  in  1  asynchronous, active-low reset
- vnotactive  in  1  high during vertical blanking
- keys  in  NKEYS  active-low key bank, synchronous to CLK
- pix_r, pix_g, pix_b  in  COLOR_W each  colour from calculator
- red, green, blue  out  COLOR_W each  registered VGA colour
- sample_num  out  SEL_W  selected preset index
- sel_valid  out  1  one-cycle pulse on new selection
- calc_rst_n  out  1  active-low calculator reset
- calc_en  out  1  calculator enable (enable, not a gated clock)
- disp_en  out  1  colour output update enable

## Operation
- Reset values: red/green/blue all ones, sample_num 0, sel_valid 0, calc_rst_n 1, calc_en 0, disp_en 0; key FSM IDLE, candidate 0, deb_cnt 0.
- Pixel path: disp_en=1 → each cycle red/green/blue ← pix_r/g/b; disp_en=0 → hold.
- Startup: tick pulses every TICK_DIV cycles. Tick counter increments per tick and saturates at STARTUP_CALC. When count reaches STARTUP_DISP, disp_en←1. When it reaches STARTUP_CALC, calc_en←1. Both stay high until reset.
- Key FSM states:
  - IDLE: vnotactive=1 → SCAN.
  - SCAN (one cycle): idx = lowest-index low key.
    - No key low: deb_cnt←0 → DONE.
    - idx≠candidate: candidate←idx, deb_cnt←1.
    - idx=candidate: deb_cnt←deb_cnt+1.
    - If the new deb_cnt equals DEB_FRAMES: commit → RELEASE. Otherwise → DONE.
  - Commit: sample_num←idx, sel_valid pulse, calc_rst_n low for RST_CYC cycles, deb_cnt←0.
  - DONE: vnotactive=0 → IDLE.
  - RELEASE: vnotactive=1 and keys all high → DONE. A new selection therefore needs a release seen in some blanking interval.
- Each blanking interval gives at most one SCAN.
- Simultaneous keys: lowest index wins.
- deb_cnt is saturating, width $clog2(DEB_FRAMES+1).
- calc_rst_n pulse is independent of calc_en. A commit before calc_en=1 still updates sample_num and pulses.

## Timing
- Pixel latency: 1 cycle.
- Commit: sel_valid and the new sample_num appear 1 cycle after SCAN. calc_rst_n is low on cycles 1..RST_CYC after SCAN.
- disp_en rises 1 cycle after the STARTUP_DISP-th tick pulse. calc_en rises 1 cycle after the STARTUP_CALC-th.
- vnotactive high for exactly 1 cycle: still produces one SCAN.
- Reset mid-pulse: calc_rst_n returns to 1 immediately (async).

## Structure
- Package chaos_pkg holds:
  - key FSM enum {IDLE, SCAN, DONE, RELEASE}
  - default parameter constants
  - COLOR_W default
- Sub-module startup_seq (CLK, RST → disp_en, calc_en) holds the tick divider and saturating counter.
- Top level holds the pixel register, key FSM, priority encoder and reset-pulse counter.

## Test plan
- Reset, TICK_DIV=4: outputs at reset values. disp_en rises after 6 ticks (24 cycles + 1), calc_en after 15 ticks (61). red=1 until disp_en, then follows pix_r 1 cycle late.
- DEB_FRAMES=2, key 3 held over 2 blanking intervals → second SCAN gives sample_num=3, one sel_valid, calc_rst_n low 4 cycles.
- Keys 2 and 7 pressed together for 2 frames → sample_num=2.
- Key 5 held for 4 frames, then released, then pressed 2 more frames → exactly two commits. The second commits only after a release seen in a blanking interval.
- Key 1 for one frame, key 4 for the next frame → no commit (candidate changes, deb_cnt=1).
- Assert RST during the calc_rst_n pulse → calc_rst_n=1, FSM IDLE, sample_num=0 at once.

Source files
------------

// File: rtl/chaos_pkg.sv
// Shared types and default parameter values for the chaos-map display/control front end.
package chaos_pkg;

  // Key-scan FSM states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SCAN    = 2'd1,
    DONE    = 2'd2,
    RELEASE = 2'd3
  } key_state_e;

  localparam int unsigned DEF_NKEYS        = 10;
  localparam int unsigned DEF_COLOR_W      = 1;
  localparam int unsigned DEF_TICK_DIV     = 4194304;
  localparam int unsigned DEF_STARTUP_DISP = 6;
  localparam int unsigned DEF_STARTUP_CALC = 15;
  localparam int unsigned DEF_DEB_FRAMES   = 2;
  localparam int unsigned DEF_RST_CYC      = 4;

endpackage

// File: rtl/chaos_display_ctrl_if.sv
// Pixel, blanking, key and control signals between the environment and the display controller.
interface chaos_display_ctrl_if
  import chaos_pkg::*;
#(
  parameter int unsigned NKEYS   = DEF_NKEYS,
  parameter int unsigned SEL_W   = $clog2(NKEYS),
  parameter int unsigned COLOR_W = DEF_COLOR_W
) ();

  logic               vnotactive;
  logic [NKEYS-1:0]   keys;
  logic [COLOR_W-1:0] pix_r;
  logic [COLOR_W-1:0] pix_g;
  logic [COLOR_W-1:0] pix_b;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic [SEL_W-1:0]   sample_num;
  logic               sel_valid;
  logic               calc_rst_n;
  logic               calc_en;
  logic               disp_en;

  // Environment side: video timing, keys and calculator colour in; display and control out
  modport master (
    output vnotactive, keys, pix_r, pix_g, pix_b,
    input  red, green, blue, sample_num, sel_valid, calc_rst_n, calc_en, disp_en
  );

  // Controller side
  modport slave (
    input  vnotactive, keys, pix_r, pix_g, pix_b,
    output red, green, blue, sample_num, sel_valid, calc_rst_n, calc_en, disp_en
  );

endinterface

// File: rtl/startup_seq.sv
// Post-reset sequencer: divides CLK into ticks and raises disp_en then calc_en at fixed tick counts.
module startup_seq
  import chaos_pkg::*;
#(
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STARTUP_DISP = DEF_STARTUP_DISP,
  parameter int unsigned STARTUP_CALC = DEF_STARTUP_CALC
) (
  input  logic CLK,
  input  logic RST,
  output logic disp_en_o,
  output logic calc_en_o
);

  localparam int unsigned DIV_W = $clog2(TICK_DIV);
  localparam int unsigned CNT_W = $clog2(STARTUP_CALC + 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_c;
  logic             disp_en_q, disp_en_d;
  logic             calc_en_q, calc_en_d;

  // Tick divider, saturating tick counter and sticky enables
  always_comb begin
    tick_c    = (div_q == DIV_W'(TICK_DIV - 1));
    div_d     = tick_c ? '0 : div_q + DIV_W'(1);
    cnt_d     = cnt_q;
    if (tick_c && (cnt_q != CNT_W'(STARTUP_CALC))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    disp_en_d = disp_en_q | (cnt_q >= CNT_W'(STARTUP_DISP));
    calc_en_d = calc_en_q | (cnt_q == CNT_W'(STARTUP_CALC));
  end

  // Sequencer state
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      div_q     <= '0;
      cnt_q     <= '0;
      disp_en_q <= 1'b0;
      calc_en_q <= 1'b0;
    end else begin
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      disp_en_q <= disp_en_d;
      calc_en_q <= calc_en_d;
    end
  end

  assign disp_en_o = disp_en_q;
  assign calc_en_o = calc_en_q;

endmodule

// File: rtl/chaos_display_ctrl.sv
// Display/control front end: registered VGA colour, startup enables, and a once-per-blanking
// debounced key scan that selects a sample preset and pulses the calculator reset.
module chaos_display_ctrl
  import chaos_pkg::*;
#(
  parameter int unsigned NKEYS        = DEF_NKEYS,
  parameter int unsigned SEL_W        = $clog2(NKEYS),
  parameter int unsigned COLOR_W      = DEF_COLOR_W,
  parameter int unsigned TICK_DIV     = DEF_TICK_DIV,
  parameter int unsigned STARTUP_DISP = DEF_STARTUP_DISP,
  parameter int unsigned STARTUP_CALC = DEF_STARTUP_CALC,
  parameter int unsigned DEB_FRAMES   = DEF_DEB_FRAMES,
  parameter int unsigned RST_CYC      = DEF_RST_CYC
) (
  input  logic                 CLK,
  input  logic                 RST,
  chaos_display_ctrl_if.slave  bus
);

  localparam int unsigned DEB_W = $clog2(DEB_FRAMES + 1);
  localparam int unsigned RC_W  = $clog2(RST_CYC + 1);

  logic               disp_en, calc_en;
  logic [COLOR_W-1:0] red_q, green_q, blue_q;

  key_state_e         state_q, state_d;
  logic [SEL_W-1:0]   cand_q, cand_d;
  logic [DEB_W-1:0]   deb_q, deb_d;
  logic [DEB_W-1:0]   deb_new_c;
  logic [SEL_W-1:0]   sample_q, sample_d;
  logic               sel_valid_q, sel_valid_d;
  logic [RC_W-1:0]    rc_q, rc_d;
  logic               calc_rst_n_q, calc_rst_n_d;
  logic [SEL_W-1:0]   idx_c;
  logic               any_low_c;

  startup_seq #(
    .TICK_DIV     (TICK_DIV),
    .STARTUP_DISP (STARTUP_DISP),
    .STARTUP_CALC (STARTUP_CALC)
  ) u_startup (
    .CLK       (CLK),
    .RST       (RST),
    .disp_en_o (disp_en),
    .calc_en_o (calc_en)
  );

  // Colour register, updated only once the display is enabled
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      red_q   <= '1;
      green_q <= '1;
      blue_q  <= '1;
    end else if (disp_en) begin
      red_q   <= bus.pix_r;
      green_q <= bus.pix_g;
      blue_q  <= bus.pix_b;
    end
  end

  // Priority encoder: lowest-index pressed (low) key wins
  always_comb begin
    idx_c     = '0;
    any_low_c = ~&bus.keys;
    for (int i = int'(NKEYS) - 1; i >= 0; i--) begin
      if (!bus.keys[i]) idx_c = SEL_W'(i);
    end
  end

  // Key FSM next state, debounce bookkeeping and reset-pulse countdown
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    deb_d       = deb_q;
    sample_d    = sample_q;
    sel_valid_d = 1'b0;
    rc_d        = (rc_q != '0) ? rc_q - RC_W'(1) : rc_q;
    deb_new_c   = (deb_q == DEB_W'(DEB_FRAMES)) ? deb_q : deb_q + DEB_W'(1);
    if (idx_c != cand_q) deb_new_c = DEB_W'(1);

    case (state_q)
      IDLE: begin
        if (bus.vnotactive) state_d = SCAN;
      end
      SCAN: begin
        if (!any_low_c) begin
          deb_d   = '0;
          state_d = DONE;
        end else begin
          cand_d = idx_c;
          if (deb_new_c == DEB_W'(DEB_FRAMES)) begin
            sample_d    = idx_c;
            sel_valid_d = 1'b1;
            rc_d        = RC_W'(RST_CYC);
            deb_d       = '0;
            state_d     = RELEASE;
          end else begin
            deb_d   = deb_new_c;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (!bus.vnotactive) state_d = IDLE;
      end
      RELEASE: begin
        if (bus.vnotactive && (&bus.keys)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    calc_rst_n_d = (rc_d == '0);
  end

  // Key FSM and control output registers
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q      <= IDLE;
      cand_q       <= '0;
      deb_q        <= '0;
      sample_q     <= '0;
      sel_valid_q  <= 1'b0;
      rc_q         <= '0;
      calc_rst_n_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      cand_q       <= cand_d;
      deb_q        <= deb_d;
      sample_q     <= sample_d;
      sel_valid_q  <= sel_valid_d;
      rc_q         <= rc_d;
      calc_rst_n_q <= calc_rst_n_d;
    end
  end

  assign bus.red        = red_q;
  assign bus.green      = green_q;
  assign bus.blue       = blue_q;
  assign bus.sample_num = sample_q;
  assign bus.sel_valid  = sel_valid_q;
  assign bus.calc_rst_n = calc_rst_n_q;
  assign bus.calc_en    = calc_en;
  assign bus.disp_en    = disp_en;

endmodule

// File: tb/tb_chaos_display_ctrl.sv
// Self-checking bench for chaos_display_ctrl: startup timing, pixel path and frame-level key debounce.
module tb_chaos_display_ctrl;

  localparam int unsigned NK = 10;
  localparam int unsigned SW = 4;
  localparam int unsigned CW = 1;
  localparam int unsigned TD = 4;
  localparam int unsigned SD = 6;
  localparam int unsigned SC = 15;
  localparam int unsigned DF = 2;
  localparam int unsigned RC = 4;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  chaos_display_ctrl_if #(.NKEYS(NK), .SEL_W(SW), .COLOR_W(CW)) bus ();

  chaos_display_ctrl #(
    .NKEYS(NK), .SEL_W(SW), .COLOR_W(CW), .TICK_DIV(TD), .STARTUP_DISP(SD),
    .STARTUP_CALC(SC), .DEB_FRAMES(DF), .RST_CYC(RC)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Frame-level reference model of the key selector
  int m_cand   = 0;
  int m_cnt    = 0;
  bit m_wait   = 0;
  int m_sample = 0;

  function automatic logic [NK-1:0] keymask(input int a, input int b);
    logic [NK-1:0] m;
    m = '1;
    if (a >= 0) m[a] = 1'b0;
    if (b >= 0) m[b] = 1'b0;
    return m;
  endfunction

  function automatic int lowest(input logic [NK-1:0] kv);
    for (int i = 0; i < int'(NK); i++) if (!kv[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_cand = 0; m_cnt = 0; m_wait = 0; m_sample = 0;
  endtask

  // One video frame: keys held, short active period, blanking of 'blank' cycles, tail of active time.
  task automatic frame(input logic [NK-1:0] kv, input int blank, output int nsel);
    bit commit;
    int idx, old_s;
    logic exp_sel, exp_rn;
    logic [SW-1:0] exp_s;
    old_s  = m_sample;
    commit = 0;
    idx    = lowest(kv);
    if (m_wait) begin
      if (idx < 0) m_wait = 0;
    end else if (idx < 0) begin
      m_cnt = 0;
    end else begin
      if (idx != m_cand) begin m_cand = idx; m_cnt = 1; end
      else if (m_cnt < int'(DF)) m_cnt++;
      if (m_cnt == int'(DF)) begin
        commit = 1; m_sample = idx; m_cnt = 0; m_wait = 1;
      end
    end
    nsel = 0;
    @(negedge CLK);
    bus.keys       = kv;
    bus.vnotactive = 1'b0;
    repeat (2) @(negedge CLK);
    for (int k = 0; k < blank + 10; k++) begin
      if (k > 0) @(negedge CLK);
      exp_sel = commit && (k == 2);
      exp_rn  = !(commit && (k >= 2) && (k < 2 + int'(RC)));
      exp_s   = (commit && k >= 2) ? SW'(m_sample) : SW'(old_s);
      if (bus.sel_valid) nsel++;
      checks++;
      if (bus.sel_valid !== exp_sel) begin
        errors++;
        $display("FAIL sel_valid k=%0d got %b want %b keys=%b", k, bus.sel_valid, exp_sel, kv);
      end
      checks++;
      if (bus.calc_rst_n !== exp_rn) begin
        errors++;
        $display("FAIL calc_rst_n k=%0d got %b want %b keys=%b", k, bus.calc_rst_n, exp_rn, kv);
      end
      checks++;
      if (bus.sample_num !== exp_s) begin
        errors++;
        $display("FAIL sample_num k=%0d got %0d want %0d keys=%b", k, bus.sample_num, exp_s, kv);
      end
      bus.vnotactive = (k < blank);
      bus.pix_r = CW'($urandom);
      bus.pix_g = CW'($urandom);
      bus.pix_b = CW'($urandom);
    end
  endtask

  task automatic test_reset();
    logic [3*CW-1:0] exp_rgb, cur_rgb;
    RST = 1'b0;
    bus.vnotactive = 1'b0;
    bus.keys  = '1;
    bus.pix_r = '0; bus.pix_g = '0; bus.pix_b = '0;
    model_reset();
    #12;
    checks++;
    if ({bus.red, bus.green, bus.blue, bus.sample_num, bus.sel_valid, bus.calc_rst_n,
         bus.calc_en, bus.disp_en} !== {{(3*CW){1'b1}}, {SW{1'b0}}, 4'b0100}) begin
      errors++;
      $display("FAIL reset_values got rgb=%b s=%0d sv=%b rn=%b ce=%b de=%b",
               {bus.red, bus.green, bus.blue}, bus.sample_num, bus.sel_valid,
               bus.calc_rst_n, bus.calc_en, bus.disp_en);
    end
    @(negedge CLK);
    RST = 1'b1;
    exp_rgb = '1;
    cur_rgb = {bus.pix_r, bus.pix_g, bus.pix_b};
    for (int n = 1; n <= 70; n++) begin
      @(posedge CLK);
      if (n - 1 >= int'(SD * TD) + 1) exp_rgb = cur_rgb;
      #1;
      checks++;
      if (bus.disp_en !== (n >= int'(SD * TD) + 1)) begin
        errors++;
        $display("FAIL disp_en edge=%0d got %b want %b", n, bus.disp_en, (n >= int'(SD * TD) + 1));
      end
      checks++;
      if (bus.calc_en !== (n >= int'(SC * TD) + 1)) begin
        errors++;
        $display("FAIL calc_en edge=%0d got %b want %b", n, bus.calc_en, (n >= int'(SC * TD) + 1));
      end
      checks++;
      if ({bus.red, bus.green, bus.blue} !== exp_rgb) begin
        errors++;
        $display("FAIL pixel edge=%0d got %b want %b", n, {bus.red, bus.green, bus.blue}, exp_rgb);
      end
      #1;
      bus.pix_r = CW'($urandom);
      bus.pix_g = CW'($urandom);
      bus.pix_b = CW'($urandom);
      cur_rgb = {bus.pix_r, bus.pix_g, bus.pix_b};
    end
  endtask

  task automatic test_single_key();
    int ns, tot;
    tot = 0;
    frame(keymask(3, -1), 3, ns); tot += ns;
    frame(keymask(3, -1), 2, ns); tot += ns;
    frame(keymask(-1, -1), 2, ns); tot += ns;
    checks++;
    if (tot !== 1 || bus.sample_num !== SW'(3)) begin
      errors++;
      $display("FAIL single_key got pulses=%0d sample=%0d want 1 and 3", tot, bus.sample_num);
    end
  endtask

  task automatic test_simultaneous();
    int ns;
    frame(keymask(2, 7), 1, ns);
    frame(keymask(2, 7), 1, ns);
    checks++;
    if (bus.sample_num !== SW'(2)) begin
      errors++;
      $display("FAIL simultaneous got %0d want 2", bus.sample_num);
    end
    frame(keymask(-1, -1), 1, ns);
  endtask

  task automatic test_hold_release();
    int ns, tot;
    tot = 0;
    repeat (4) begin frame(keymask(5, -1), 2, ns); tot += ns; end
    frame(keymask(-1, -1), 2, ns); tot += ns;
    repeat (2) begin frame(keymask(5, -1), 2, ns); tot += ns; end
    checks++;
    if (tot !== 2) begin
      errors++;
      $display("FAIL hold_release got %0d commits want 2", tot);
    end
    frame(keymask(-1, -1), 2, ns);
  endtask

  task automatic test_candidate_change();
    int ns, tot;
    tot = 0;
    frame(keymask(1, -1), 2, ns); tot += ns;
    frame(keymask(4, -1), 2, ns); tot += ns;
    checks++;
    if (tot !== 0) begin
      errors++;
      $display("FAIL candidate_change got %0d commits want 0", tot);
    end
    frame(keymask(-1, -1), 2, ns);
  endtask

  task automatic test_random();
    int ns, r, a, b;
    a = 0;
    for (int f = 0; f < 40; f++) begin
      r = int'($urandom_range(0, 9));
      if ($urandom_range(0, 2) == 0) a = int'($urandom_range(0, NK - 1));
      b = int'($urandom_range(0, NK - 1));
      if (r < 3)      frame(keymask(-1, -1), int'($urandom_range(1, 4)), ns);
      else if (r < 8) frame(keymask(a, -1), int'($urandom_range(1, 4)), ns);
      else            frame(keymask(a, b), int'($urandom_range(1, 4)), ns);
    end
  endtask

  task automatic test_reset_mid_pulse();
    int ns, tot;
    frame(keymask(-1, -1), 2, ns);
    frame(keymask(-1, -1), 2, ns);
    frame(keymask(6, -1), 2, ns);
    @(negedge CLK);
    bus.keys = keymask(6, -1);
    repeat (2) @(negedge CLK);
    bus.vnotactive = 1'b1;
    @(negedge CLK);
    bus.vnotactive = 1'b0;
    @(negedge CLK);
    checks++;
    if (bus.calc_rst_n !== 1'b0 || bus.sel_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_commit got rn=%b sv=%b want 0 1", bus.calc_rst_n, bus.sel_valid);
    end
    @(negedge CLK);
    RST = 1'b0;
    #1;
    checks++;
    if ({bus.calc_rst_n, bus.sample_num, bus.sel_valid, bus.disp_en} !== {1'b1, {SW{1'b0}}, 2'b00}) begin
      errors++;
      $display("FAIL async_reset got rn=%b s=%0d sv=%b de=%b want 1 0 0 0",
               bus.calc_rst_n, bus.sample_num, bus.sel_valid, bus.disp_en);
    end
    @(negedge CLK);
    RST = 1'b1;
    model_reset();
    tot = 0;
    frame(keymask(6, -1), 2, ns); tot += ns;
    frame(keymask(6, -1), 2, ns); tot += ns;
    checks++;
    if (tot !== 1 || bus.sample_num !== SW'(6)) begin
      errors++;
      $display("FAIL post_reset_idle got pulses=%0d sample=%0d want 1 and 6", tot, bus.sample_num);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single_key();
    test_simultaneous();
    test_hold_release();
    test_candidate_change();
    test_random();
    test_reset_mid_pulse();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
